// File: rtl/lc3_psr_pkg.sv
// Shared field positions, reset value and condition-code helpers for the LC-3 PSR unit.
package lc3_psr_pkg;

  // PRIV_BIT is the 16-bit position; wider PSRs keep privilege in the MSB.
  localparam int unsigned PRIV_BIT = 15;
  localparam int unsigned PRIO_LSB = 8;
  localparam int unsigned NZP_N    = 2;
  localparam int unsigned NZP_Z    = 1;
  localparam int unsigned NZP_P    = 0;

  localparam logic [2:0]  NZP_RESET = 3'b010;
  localparam logic [63:0] PSR_RESET = 64'(NZP_RESET);

  // Bus arrives zero-extended to 64 bits; width selects the sign bit.
  function automatic logic [2:0] nzp_from_bus(input logic [63:0] bus, input int unsigned width);
    logic n;
    logic z;
    n = |(bus & (64'd1 << (width - 1)));
    z = (bus == '0);
    return {n, z, !n && !z};
  endfunction

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/lc3_psr_stack.sv
// LIFO of saved PSRs; illegal push/pop combinations are dropped and flagged on err.
module lc3_psr_stack
  import lc3_psr_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned SAVE_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  logic                              pop,
  input  logic [DATA_W-1:0]                 din,
  output logic [DATA_W-1:0]                 dout,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(SAVE_DEPTH+1)-1:0]   count,
  output logic                              err
);

  localparam int unsigned CW = $clog2(SAVE_DEPTH + 1);
  localparam int unsigned AW = (SAVE_DEPTH > 1) ? $clog2(SAVE_DEPTH) : 1;

  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] mem_q [SAVE_DEPTH];
  logic              do_push, do_pop;
  logic [AW-1:0]     wr_idx, rd_idx;

  always_comb begin
    full    = (count_q == CW'(SAVE_DEPTH));
    empty   = (count_q == '0);
    do_push = push && !pop && !full;
    do_pop  = pop && !push && !empty;
    err     = (push && pop) || (push && full) || (pop && empty);
    count_d = count_q;
    if (do_push)     count_d = count_q + 1'b1;
    else if (do_pop) count_d = count_q - 1'b1;
    wr_idx  = AW'(count_q);
    rd_idx  = AW'(count_q - 1'b1);
    dout    = empty ? '0 : mem_q[rd_idx];
    count   = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/lc3_psr_ctl.sv
// LC-3 processor status unit: PSR, registered BEN and a nested-interrupt PSR save stack.
module lc3_psr_ctl
  import lc3_psr_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned PRIO_W     = 3,
  parameter int unsigned SAVE_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             LDBEN,
  input  logic [DATA_W-1:0]                IR,
  input  logic [DATA_W-1:0]                main_bus,
  input  logic                             LDCC,
  input  logic                             LDPSR,
  input  logic                             INT_ENTER,
  input  logic [PRIO_W-1:0]                INT_PRIO,
  input  logic                             RTI_POP,
  input  logic                             CLR_ERR,
  output logic                             BEN,
  output logic [DATA_W-1:0]                PSR,
  output logic                             priv_user,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             stack_err,
  output logic [$clog2(SAVE_DEPTH+1)-1:0]  save_count
);

  logic [DATA_W-1:0] psr_q, psr_d;
  logic              ben_q, ben_d;
  logic              err_q, err_d;
  logic [2:0]        cc_bus;
  logic [DATA_W-1:0] stk_top;
  logic              stk_empty, stk_err;
  logic              unused_ir;

  assign unused_ir = ^{IR[DATA_W-1:12], IR[8:0]};

  lc3_psr_stack #(
    .DATA_W     (DATA_W),
    .SAVE_DEPTH (SAVE_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst_n (rst),
    .push  (INT_ENTER),
    .pop   (RTI_POP),
    .din   (psr_q),
    .dout  (stk_top),
    .full  (stack_full),
    .empty (stk_empty),
    .count (save_count),
    .err   (stk_err)
  );

  always_comb begin
    psr_d  = psr_q;
    ben_d  = ben_q;
    err_d  = err_q;
    cc_bus = nzp_from_bus(64'(main_bus), DATA_W);

    if (LDBEN) ben_d = |(IR[11:9] & psr_q[NZP_N:NZP_P]);

    if (LDCC) psr_d[NZP_N:NZP_P] = cc_bus;
    if (LDPSR) begin
      psr_d                      = '0;
      psr_d[DATA_W-1]            = main_bus[DATA_W-1];
      psr_d[PRIO_LSB +: PRIO_W]  = main_bus[PRIO_LSB +: PRIO_W];
      psr_d[NZP_N:NZP_P]         = is_onehot3(main_bus[2:0]) ? main_bus[2:0] : NZP_RESET;
    end

    // Interrupt entry overrides LDPSR, but a concurrent LDCC still lands in the new PSR's NZP.
    if (INT_ENTER && !RTI_POP) begin
      psr_d                     = '0;
      psr_d[PRIO_LSB +: PRIO_W] = INT_PRIO;
      psr_d[NZP_N:NZP_P]        = LDCC ? cc_bus : psr_q[NZP_N:NZP_P];
    end else if (RTI_POP && !INT_ENTER) begin
      psr_d = stk_empty ? psr_q : stk_top;
    end

    if (CLR_ERR) err_d = 1'b0;
    if (stk_err) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      psr_q <= PSR_RESET[DATA_W-1:0];
      ben_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      psr_q <= psr_d;
      ben_q <= ben_d;
      err_q <= err_d;
    end
  end

  assign PSR         = psr_q;
  assign BEN         = ben_q;
  assign priv_user   = psr_q[DATA_W-1];
  assign stack_empty = stk_empty;
  assign stack_err   = err_q;

endmodule
